// File: rtl/sram_port_arbiter_if.sv
// Bundle of the inst port, data port and SRAM port around sram_port_arbiter.
// slave = arbiter side, master = pipeline/SRAM side.
interface sram_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  localparam int BE_W = DATA_W / 8;

  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              i_gnt;
  logic              i_rsp_valid;
  logic [DATA_W-1:0] i_rdata;

  logic              d_req;
  logic [BE_W-1:0]   d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rsp_valid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic [BE_W-1:0]   mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              stallreq;
  logic [31:0]       conflict_cnt;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output i_gnt, i_rsp_valid, i_rdata, d_gnt, d_rsp_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stallreq, conflict_cnt
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  i_gnt, i_rsp_valid, i_rdata, d_gnt, d_rsp_valid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata, stallreq, conflict_cnt
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported SRAM between inst fetch and load/store: data-first
// arbitration with bounded inst starvation, one-cycle response steering.
module sram_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input logic                clock,
  input logic                reset,
  sram_port_arbiter_if.slave bus
);
  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, RESP_I, RESP_D} state_t;

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_starve, w_starve_nxt;
  logic [DATA_W-1:0] r_i_hold, r_d_hold;
  logic [31:0]       r_conflict;
  logic              w_i_win, w_d_win, w_i_gnt, w_d_gnt;

  // Data normally wins; a saturated starve count hands the slot to inst.
  always_comb begin
    w_i_win = bus.i_req & (~bus.d_req | (r_starve == STARVE_LIM));
    w_d_win = bus.d_req & ~w_i_win;
    w_i_gnt = w_i_win & ~reset;
    w_d_gnt = w_d_win & ~reset;
  end

  always_comb begin
    w_state_nxt = IDLE;
    if (w_d_gnt)      w_state_nxt = RESP_D;
    else if (w_i_gnt) w_state_nxt = RESP_I;
  end

  always_comb begin
    w_starve_nxt = r_starve;
    if (~bus.i_req | w_i_gnt)      w_starve_nxt = '0;
    else if (r_starve != STARVE_LIM) w_starve_nxt = r_starve + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_starve   <= '0;
      r_i_hold   <= '0;
      r_d_hold   <= '0;
      r_conflict <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_starve <= w_starve_nxt;
      if (r_state == RESP_I) r_i_hold <= bus.mem_rdata;
      if (r_state == RESP_D) r_d_hold <= bus.mem_rdata;
      if (bus.i_req & bus.d_req) r_conflict <= r_conflict + 32'd1;
    end
  end

  assign bus.i_gnt        = w_i_gnt;
  assign bus.d_gnt        = w_d_gnt;
  assign bus.mem_en       = w_i_gnt | w_d_gnt;
  assign bus.mem_addr     = w_d_gnt ? bus.d_addr  : bus.i_addr;
  assign bus.mem_we       = w_d_gnt ? bus.d_we    : {BE_W{1'b0}};
  assign bus.mem_wdata    = w_d_gnt ? bus.d_wdata : {DATA_W{1'b0}};

  assign bus.i_rsp_valid  = (r_state == RESP_I);
  assign bus.d_rsp_valid  = (r_state == RESP_D);
  assign bus.i_rdata      = (r_state == RESP_I) ? bus.mem_rdata : r_i_hold;
  assign bus.d_rdata      = (r_state == RESP_D) ? bus.mem_rdata : r_d_hold;

  assign bus.stallreq     = (bus.i_req & ~w_i_gnt) | (bus.d_req & ~w_d_gnt);
  assign bus.conflict_cnt = r_conflict;
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: SRAM model, per-cycle reference model
// of arbitration/responses, plus hand-computed checkpoints.
module tb_sram_port_arbiter;
  localparam int AW = 64, DW = 64, BW = 8, SM = 4;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  sram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();
  sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SM)) dut (
    .clock(clock), .reset(reset), .bus(bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] idx(input logic [AW-1:0] a);
    return {a[14:12], a[7:3]};
  endfunction

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [BW-1:0] we);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < BW; b++) if (we[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  // SRAM: synchronous read, write commits at the enable edge.
  logic [DW-1:0] sram [0:255];
  always @(posedge clock) begin
    if (bus.mem_en) begin
      bus.mem_rdata <= sram[idx(bus.mem_addr)];
      if (bus.mem_we != '0)
        sram[idx(bus.mem_addr)] = merge(sram[idx(bus.mem_addr)], bus.mem_wdata, bus.mem_we);
    end
  end

  // Reference model: memory image, consecutive inst denials, expected response.
  logic [DW-1:0] refm [0:255];
  bit            chk_en   = 1'b0;
  int            m_denied = 0;
  int            m_rsp    = 0;   // 0 none, 1 inst, 2 data
  logic [DW-1:0] m_rsp_data = '0;
  bit            m_rsp_known = 1'b1;
  logic [DW-1:0] m_ih = '0, m_dh = '0;
  bit            m_dk = 1'b1;
  logic [31:0]   m_conf = '0;

  always @(negedge clock) begin
    if (chk_en) begin
      logic eig, edg;
      eig = !reset && bus.i_req && (!bus.d_req || m_denied >= SM);
      edg = !reset && bus.d_req && !eig;
      chk("i_gnt",    64'(bus.i_gnt),    64'(eig));
      chk("d_gnt",    64'(bus.d_gnt),    64'(edg));
      chk("mem_en",   64'(bus.mem_en),   64'(eig | edg));
      chk("mem_we",   64'(bus.mem_we),   edg ? 64'(bus.d_we) : 64'd0);
      if (eig | edg) chk("mem_addr", bus.mem_addr, edg ? bus.d_addr : bus.i_addr);
      if (edg && bus.d_we != '0) chk("mem_wdata", bus.mem_wdata, bus.d_wdata);
      chk("stallreq", 64'(bus.stallreq),
          64'((bus.i_req && !eig) || (bus.d_req && !edg)));
      chk("i_rsp_valid", 64'(bus.i_rsp_valid), 64'(m_rsp == 1));
      chk("d_rsp_valid", 64'(bus.d_rsp_valid), 64'(m_rsp == 2));
      chk("i_rdata", bus.i_rdata, (m_rsp == 1) ? m_rsp_data : m_ih);
      if (m_rsp == 2 ? m_rsp_known : m_dk)
        chk("d_rdata", bus.d_rdata, (m_rsp == 2) ? m_rsp_data : m_dh);
      chk("conflict_cnt", 64'(bus.conflict_cnt), 64'(m_conf));

      if (reset) begin
        m_denied = 0; m_rsp = 0; m_ih = '0; m_dh = '0; m_dk = 1'b1; m_conf = '0;
      end else begin
        if (m_rsp == 1) m_ih = m_rsp_data;
        if (m_rsp == 2) begin m_dh = m_rsp_data; m_dk = m_rsp_known; end
        if (bus.i_req && bus.d_req) m_conf = m_conf + 32'd1;
        m_denied = (bus.i_req && !eig) ? m_denied + 1 : 0;
        if (eig) begin
          m_rsp = 1; m_rsp_data = refm[idx(bus.i_addr)]; m_rsp_known = 1'b1;
        end else if (edg) begin
          m_rsp = 2;
          m_rsp_known = (bus.d_we == '0);
          m_rsp_data  = refm[idx(bus.d_addr)];
          if (bus.d_we != '0)
            refm[idx(bus.d_addr)] = merge(refm[idx(bus.d_addr)], bus.d_wdata, bus.d_we);
        end else m_rsp = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clock); #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sram[idx(a)] = d;
    refm[idx(a)] = d;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin sram[i] = '0; refm[i] = '0; end
    preload(64'h8000_0000, 64'h1234);
    preload(64'h8000_0008, 64'h77);
    preload(64'h8000_1000, 64'h55);
    preload(64'h8000_0018, 64'hAA);
    reset = 1'b1;
    bus.i_req = 1'b0; bus.i_addr = '0;
    bus.d_req = 1'b0; bus.d_we = '0; bus.d_addr = '0; bus.d_wdata = '0;
    tick; chk_en = 1'b1;
    @(negedge clock);
    chk("rst_i_rsp_valid", 64'(bus.i_rsp_valid), 64'd0);
    chk("rst_conflict",    64'(bus.conflict_cnt), 64'd0);

    // inst read alone
    tick; reset = 1'b0; bus.i_req = 1'b1; bus.i_addr = 64'h8000_0000;
    @(negedge clock);
    chk("t1_i_gnt", 64'(bus.i_gnt), 64'd1);
    chk("t1_stall", 64'(bus.stallreq), 64'd0);
    tick; bus.i_req = 1'b0;
    @(negedge clock);
    chk("t1_rsp_valid", 64'(bus.i_rsp_valid), 64'd1);
    chk("t1_rdata", bus.i_rdata, 64'h1234);

    // simultaneous requests
    tick; bus.i_req = 1'b1; bus.i_addr = 64'h8000_0008;
    bus.d_req = 1'b1; bus.d_addr = 64'h8000_1000;
    @(negedge clock);
    chk("t2_d_gnt", 64'(bus.d_gnt), 64'd1);
    chk("t2_stall", 64'(bus.stallreq), 64'd1);
    tick; bus.d_req = 1'b0;
    @(negedge clock);
    chk("t2_i_gnt", 64'(bus.i_gnt), 64'd1);
    chk("t2_d_rsp", 64'(bus.d_rsp_valid), 64'd1);
    chk("t2_d_rdata", bus.d_rdata, 64'h55);
    chk("t2_conflict", 64'(bus.conflict_cnt), 64'd1);
    tick; bus.i_req = 1'b0;
    @(negedge clock);
    chk("t2_i_rsp", 64'(bus.i_rsp_valid), 64'd1);
    chk("t2_i_rdata", bus.i_rdata, 64'h77);

    // starvation under continuous data traffic
    tick; bus.i_req = 1'b1; bus.i_addr = 64'h8000_0010;
    bus.d_req = 1'b1; bus.d_addr = 64'h8000_3000;
    for (int k = 0; k < 10; k++) begin
      @(negedge clock);
      if (k < 4) chk("t3_d_wins", 64'({bus.d_gnt, bus.i_gnt}), 64'd2);
      else if (k == 4) chk("t3_i_forced", 64'({bus.d_gnt, bus.i_gnt}), 64'd1);
      else if (k == 5) begin
        chk("t3_d_again", 64'(bus.d_gnt), 64'd1);
        chk("t3_conflict", 64'(bus.conflict_cnt), 64'd6);
      end
      tick;
      if (k == 4) bus.i_req = 1'b0;
      if (k == 9) bus.d_req = 1'b0;
    end

    // write then read same address
    bus.d_req = 1'b1; bus.d_we = 8'hFF; bus.d_wdata = 64'hDEADBEEF; bus.d_addr = 64'h8000_2000;
    @(negedge clock);
    chk("t4_mem_we", 64'(bus.mem_we), 64'hFF);
    tick; bus.d_we = '0;
    @(negedge clock);
    chk("t4_wr_rsp", 64'(bus.d_rsp_valid), 64'd1);
    tick; bus.d_req = 1'b0;
    @(negedge clock);
    chk("t4_rd_rsp", 64'(bus.d_rsp_valid), 64'd1);
    chk("t4_rdata", bus.d_rdata, 64'hDEADBEEF);

    // inst hold register across data-only traffic
    tick; bus.i_req = 1'b1; bus.i_addr = 64'h8000_0018;
    tick; bus.i_req = 1'b0; bus.d_req = 1'b1; bus.d_addr = 64'h8000_1000;
    @(negedge clock);
    chk("t5_i_rdata", bus.i_rdata, 64'hAA);
    for (int k = 0; k < 3; k++) begin
      tick;
      if (k == 2) bus.d_req = 1'b0;
      @(negedge clock);
      chk("t5_hold", bus.i_rdata, 64'hAA);
    end

    // reset mid-operation
    tick; bus.d_req = 1'b1; bus.d_addr = 64'h8000_1000;
    @(negedge clock);
    chk("t6_d_gnt", 64'(bus.d_gnt), 64'd1);
    tick; reset = 1'b1;
    @(negedge clock);
    chk("t6_mem_en_rst", 64'(bus.mem_en), 64'd0);
    chk("t6_d_gnt_rst",  64'(bus.d_gnt),  64'd0);
    tick; reset = 1'b0; bus.d_req = 1'b0;
    @(negedge clock);
    chk("t6_no_rsp",   64'(bus.d_rsp_valid), 64'd0);
    chk("t6_d_hold",   bus.d_rdata, 64'd0);
    chk("t6_i_hold",   bus.i_rdata, 64'd0);
    chk("t6_conflict", 64'(bus.conflict_cnt), 64'd0);
    tick; tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
